si4463_cmd_seq: RTL and testbench

SI4463_CMD_SEQ -- requirements
Module: si4463_cmd_seq

---
 rtl/si4463_cmd_seq.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_si4463_cmd_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/si4463_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : si4463_cmd_seq
// Description : Si4463 command sequencer. Sends a buffered command through a
//               register-mapped SPI master, polls CTS until the radio answers
//               0xFF, then reads the response bytes into a response buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module si4463_cmd_seq #(
  parameter int CTS_MAX_POLLS = 100,
  parameter int POLL_GAP      = 50
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cmd_wr_i,
  input  logic [3:0]  cmd_waddr_i,
  input  logic [7:0]  cmd_wdata_i,
  input  logic [4:0]  cmd_len_i,
  input  logic [4:0]  resp_len_i,
  input  logic        start_i,
  input  logic [3:0]  resp_raddr_i,
  output logic [7:0]  resp_rdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_timeout_o,
  output logic        err_len_o,
  output logic        spi_select_o,
  output logic        spi_write_n_o,
  output logic        spi_read_n_o,
  output logic [2:0]  spi_addr_o,
  output logic [15:0] spi_wdata_o,
  input  logic [15:0] spi_rdata_i,
  input  logic        spi_dataavailable_i,
  input  logic        spi_tmt_i
);

  localparam int PW = $clog2(CTS_MAX_POLLS + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(CTS_MAX_POLLS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

  localparam logic [2:0]  REG_RX   = 3'd0;
  localparam logic [2:0]  REG_TX   = 3'd1;
  localparam logic [2:0]  REG_CTRL = 3'd3;
  localparam logic [15:0] SS_FORCE = 16'h0400;

  // Sub-steps of one byte exchange
  localparam logic [1:0] STEP_TMT = 2'd0;
  localparam logic [1:0] STEP_WR  = 2'd1;
  localparam logic [1:0] STEP_RDY = 2'd2;
  localparam logic [1:0] STEP_RD  = 2'd3;

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_SS_ON_C, ST_CMD, ST_SS_OFF_C, ST_GAP,
    ST_SS_ON_P, ST_POLL, ST_CTS, ST_RESP, ST_SS_OFF_P, ST_DONE
  } state_t;

  // Register-bus access engine: two asserted cycles then one released cycle
  typedef enum logic [1:0] {B_IDLE, B_A1, B_A2, B_REL} bphase_t;

  state_t        state_q, state_d;
  bphase_t       bphase_q, bphase_d;
  logic [1:0]    step_q, step_d;
  logic [2:0]    baddr_q, baddr_d;
  logic [15:0]   bwdata_q, bwdata_d;
  logic          brd_q, brd_d;
  logic [7:0]    rx_q, rx_d;
  logic [4:0]    cmd_len_q, cmd_len_d;
  logic [4:0]    resp_len_q, resp_len_d;
  logic [4:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          err_len_q, err_len_d;
  logic          err_to_q, err_to_d;
  logic          fin_q, fin_d;

  logic [7:0]    cmd_buf_q  [16];
  logic [7:0]    resp_buf_q [16];

  logic          bus_req, req_rd, bus_done, xchg_done, resp_we, len_ok;
  logic [2:0]    req_addr;
  logic [15:0]   req_wdata;
  logic [7:0]    tx_byte;
  logic          unused_rdata_hi;

  assign unused_rdata_hi = ^spi_rdata_i[15:8];
  assign bus_done = (bphase_q == B_REL);
  assign len_ok   = (cmd_len_i != 5'd0) && (cmd_len_i <= 5'd16) && (resp_len_i <= 5'd16);

  // Next-state logic for the sequencer, the byte exchange and the bus engine
  always_comb begin
    state_d    = state_q;
    bphase_d   = bphase_q;
    step_d     = step_q;
    baddr_d    = baddr_q;
    bwdata_d   = bwdata_q;
    brd_d      = brd_q;
    rx_d       = rx_q;
    cmd_len_d  = cmd_len_q;
    resp_len_d = resp_len_q;
    idx_d      = idx_q;
    poll_d     = poll_q;
    gap_d      = gap_q;
    err_len_d  = err_len_q;
    err_to_d   = err_to_q;
    fin_d      = fin_q;
    bus_req    = 1'b0;
    req_rd     = 1'b0;
    req_addr   = 3'd0;
    req_wdata  = 16'h0000;
    xchg_done  = 1'b0;
    resp_we    = 1'b0;

    // Slave-select control writes
    if (state_q inside {ST_INIT, ST_SS_ON_C, ST_SS_OFF_C, ST_SS_ON_P, ST_SS_OFF_P}) begin
      bus_req   = 1'b1;
      req_addr  = REG_CTRL;
      req_wdata = (state_q == ST_SS_ON_C || state_q == ST_SS_ON_P) ? SS_FORCE : 16'h0000;
    end

    case (state_q)
      ST_CMD:  tx_byte = cmd_buf_q[idx_q[3:0]];
      ST_POLL: tx_byte = 8'h44;
      default: tx_byte = 8'h00;
    endcase

    // Byte exchange: wait TMT, write TX, wait RRDY, read RX
    if (state_q inside {ST_CMD, ST_POLL, ST_CTS, ST_RESP}) begin
      case (step_q)
        STEP_TMT: if (spi_tmt_i) step_d = STEP_WR;
        STEP_WR: begin
          bus_req   = 1'b1;
          req_addr  = REG_TX;
          req_wdata = {8'h00, tx_byte};
          if (bus_done) step_d = STEP_RDY;
        end
        STEP_RDY: if (spi_dataavailable_i) step_d = STEP_RD;
        default: begin
          bus_req  = 1'b1;
          req_rd   = 1'b1;
          req_addr = REG_RX;
          if (bus_done) begin
            step_d    = STEP_TMT;
            xchg_done = 1'b1;
          end
        end
      endcase
    end

    case (state_q)
      ST_INIT:     if (bus_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            cmd_len_d  = cmd_len_i;
            resp_len_d = resp_len_i;
            idx_d      = 5'd0;
            poll_d     = '0;
            step_d     = STEP_TMT;
            err_len_d  = 1'b0;
            err_to_d   = 1'b0;
            fin_d      = 1'b0;
            state_d    = ST_SS_ON_C;
          end else begin
            err_len_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SS_ON_C:  if (bus_done) state_d = ST_CMD;
      ST_CMD: begin
        if (xchg_done) begin
          if (idx_q == cmd_len_q - 5'd1) begin
            idx_d   = 5'd0;
            state_d = ST_SS_OFF_C;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_SS_OFF_C: begin
        if (bus_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_SS_ON_P;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_SS_ON_P:  if (bus_done) state_d = ST_POLL;
      ST_POLL:     if (xchg_done) state_d = ST_CTS;
      ST_CTS: begin
        if (xchg_done) begin
          if (rx_q == 8'hFF) begin
            idx_d   = 5'd0;
            fin_d   = (resp_len_q == 5'd0);
            state_d = (resp_len_q == 5'd0) ? ST_SS_OFF_P : ST_RESP;
          end else begin
            // Not ready: either give up or release SS and poll again
            poll_d   = poll_q + 1'b1;
            fin_d    = (poll_q == POLL_LAST);
            err_to_d = (poll_q == POLL_LAST);
            state_d  = ST_SS_OFF_P;
          end
        end
      end
      ST_RESP: begin
        if (xchg_done) begin
          resp_we = 1'b1;
          if (idx_q == resp_len_q - 5'd1) begin
            fin_d   = 1'b1;
            state_d = ST_SS_OFF_P;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_SS_OFF_P: begin
        if (bus_done) begin
          gap_d   = '0;
          state_d = fin_q ? ST_DONE : ST_GAP;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_INIT;
    endcase

    case (bphase_q)
      B_IDLE: begin
        if (bus_req) begin
          baddr_d  = req_addr;
          bwdata_d = req_wdata;
          brd_d    = req_rd;
          bphase_d = B_A1;
        end
      end
      B_A1: bphase_d = B_A2;
      B_A2: begin
        if (brd_q) rx_d = spi_rdata_i[7:0];
        bphase_d = B_REL;
      end
      default: bphase_d = B_IDLE;
    endcase
  end

  // State and control registers; reset aborts any transfer at once
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_INIT;
      bphase_q   <= B_IDLE;
      step_q     <= STEP_TMT;
      baddr_q    <= 3'd0;
      bwdata_q   <= 16'h0000;
      brd_q      <= 1'b0;
      rx_q       <= 8'h00;
      cmd_len_q  <= 5'd0;
      resp_len_q <= 5'd0;
      idx_q      <= 5'd0;
      poll_q     <= '0;
      gap_q      <= '0;
      err_len_q  <= 1'b0;
      err_to_q   <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bphase_q   <= bphase_d;
      step_q     <= step_d;
      baddr_q    <= baddr_d;
      bwdata_q   <= bwdata_d;
      brd_q      <= brd_d;
      rx_q       <= rx_d;
      cmd_len_q  <= cmd_len_d;
      resp_len_q <= resp_len_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      gap_q      <= gap_d;
      err_len_q  <= err_len_d;
      err_to_q   <= err_to_d;
      fin_q      <= fin_d;
    end
  end

  // Command and response buffers, no reset so contents survive commands
  always_ff @(posedge clk_i) begin
    if (cmd_wr_i && !busy_o) cmd_buf_q[cmd_waddr_i] <= cmd_wdata_i;
    if (resp_we) resp_buf_q[idx_q[3:0]] <= rx_q;
  end

  assign resp_rdata_o  = resp_buf_q[resp_raddr_i];
  assign busy_o        = !(state_q inside {ST_INIT, ST_IDLE, ST_DONE});
  assign done_o        = (state_q == ST_DONE);
  assign err_timeout_o = err_to_q;
  assign err_len_o     = err_len_q;
  assign spi_select_o  = (bphase_q == B_A1) || (bphase_q == B_A2);
  assign spi_write_n_o = !(spi_select_o && !brd_q);
  assign spi_read_n_o  = !(spi_select_o && brd_q);
  assign spi_addr_o    = spi_select_o ? baddr_q : 3'd0;
  assign spi_wdata_o   = spi_select_o ? bwdata_q : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_si4463_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_si4463_cmd_seq
// Description : Scoreboard bench for si4463_cmd_seq with an SPI-master model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_si4463_cmd_seq;

  localparam int MAXP = 4;
  localparam int GAP  = 4;

  logic        clk = 1'b0;
  logic        reset, cmd_wr, start;
  logic [3:0]  waddr, raddr;
  logic [7:0]  wdata, rdata;
  logic [4:0]  clen, rlen;
  logic        busy, done, err_to, err_len, sel, wn, rn;
  logic [2:0]  addr;
  logic [15:0] swd;
  logic [15:0] srd  = 16'h0000;
  logic        tmt  = 1'b1;
  logic        rrdy = 1'b0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  int          sel_cnt  = 0;
  int          off_cyc  = 0;
  int          dly      = 0;
  logic        sel_prev = 1'b0;
  logic        last_off = 1'b0;
  logic [20:0] acc;
  logic [20:0] exp_q [$];
  logic [7:0]  miso_q [$];

  si4463_cmd_seq #(.CTS_MAX_POLLS(MAXP), .POLL_GAP(GAP)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_wr_i(cmd_wr), .cmd_waddr_i(waddr),
    .cmd_wdata_i(wdata), .cmd_len_i(clen), .resp_len_i(rlen), .start_i(start),
    .resp_raddr_i(raddr), .resp_rdata_o(rdata), .busy_o(busy), .done_o(done),
    .err_timeout_o(err_to), .err_len_o(err_len), .spi_select_o(sel),
    .spi_write_n_o(wn), .spi_read_n_o(rn), .spi_addr_o(addr), .spi_wdata_o(swd),
    .spi_rdata_i(srd), .spi_dataavailable_i(rrdy), .spi_tmt_i(tmt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus monitor, scoreboard compare and SPI-master model
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      sel_prev = 1'b0; sel_cnt = 0; dly = 0; tmt = 1'b1; rrdy = 1'b0; last_off = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          tmt  = 1'b1;
          rrdy = 1'b1;
          srd  = (miso_q.size() > 0) ? {8'h00, miso_q.pop_front()} : 16'h0000;
        end
      end
      if (sel && !sel_prev) begin
        acc = {rn, wn, addr, rn ? swd : 16'h0000};
        if (exp_q.size() == 0) check_eq("bus_extra", {11'h0, acc}, 32'hFFFF_FFFF);
        else                   check_eq("bus_acc", {11'h0, acc}, {11'h0, exp_q.pop_front()});
        if (!wn && addr == 3'd1) begin tmt = 1'b0; rrdy = 1'b0; dly = 3; end
        if (!rn && addr == 3'd0) rrdy = 1'b0;
        if (!wn && addr == 3'd3 && swd == 16'h0400 && last_off)
          check_eq("gap_len", {31'h0, (cyc - off_cyc) >= GAP + 3}, 32'h1);
        last_off = !wn && addr == 3'd3 && swd == 16'h0000;
        if (last_off) off_cyc = cyc;
      end
      if (sel) sel_cnt++;
      else if (sel_prev) begin
        check_eq("hold_len", sel_cnt, 2);
        sel_cnt = 0;
      end
      sel_prev = sel;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic exp_w(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({2'b10, a, d});
  endtask

  task automatic exch(input logic [7:0] tx, input logic [7:0] rx);
    exp_w(3'd1, {8'h00, tx});
    exp_q.push_back({2'b01, 3'd0, 16'h0000});
    miso_q.push_back(rx);
  endtask

  task automatic poll(input logic [7:0] cts);
    exp_w(3'd3, 16'h0400);
    exch(8'h44, 8'h00);
    exch(8'h00, cts);
  endtask

  task automatic wr_buf(input logic [3:0] a, input logic [7:0] d);
    waddr = a; wdata = d; cmd_wr = 1'b1;
    tick();
    cmd_wr = 1'b0;
  endtask

  task automatic go(input logic [4:0] cl, input logic [4:0] rl);
    clen = cl; rlen = rl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 3000) begin tick(); n++; end
    check_eq({tag, "_done_seen"}, {31'h0, done_cnt != d0}, 32'h1);
    repeat (5) tick();
    check_eq({tag, "_done_once"}, done_cnt - d0, 1);
    check_eq({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  task automatic rd_resp(input logic [3:0] a, input logic [7:0] e);
    raddr = a;
    #1;
    check_eq("resp_rdata", {24'h0, rdata}, {24'h0, e});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_wr = 1'b0; start = 1'b0; waddr = 4'd0; wdata = 8'h00;
    clen = 5'd0; rlen = 5'd0; raddr = 4'd0;
    repeat (3) tick();
    // Reset values
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_errs", {err_to, err_len}, 0);
    check_eq("rst_bus", {sel, wn, rn, addr, swd}, {3'b011, 19'h0});
    exp_w(3'd3, 16'h0000);
    reset = 1'b0;
    repeat (10) tick();
    check_eq("init_acc", exp_q.size(), 0);

    // Single byte command, CTS ready on the first poll
    wr_buf(4'd0, 8'h01);
    exp_w(3'd3, 16'h0400); exch(8'h01, 8'h00); exp_w(3'd3, 16'h0000);
    poll(8'hFF); exp_w(3'd3, 16'h0000);
    check_eq("idle_busy", busy, 0);
    go(5'd1, 5'd0);
    check_eq("busy_after_start", busy, 1);
    wait_done("t1");
    check_eq("t1_errs", {err_to, err_len}, 0);

    // Two byte command, two CTS retries, three response bytes
    wr_buf(4'd0, 8'h12); wr_buf(4'd1, 8'h34);
    exp_w(3'd3, 16'h0400); exch(8'h12, 8'h00); exch(8'h34, 8'h00); exp_w(3'd3, 16'h0000);
    poll(8'h00); exp_w(3'd3, 16'h0000);
    poll(8'h00); exp_w(3'd3, 16'h0000);
    poll(8'hFF); exch(8'h00, 8'hAA); exch(8'h00, 8'hBB); exch(8'h00, 8'hCC);
    exp_w(3'd3, 16'h0000);
    go(5'd2, 5'd3);
    wait_done("t2");
    rd_resp(4'd0, 8'hAA); rd_resp(4'd1, 8'hBB); rd_resp(4'd2, 8'hCC);
    check_eq("t2_errs", {err_to, err_len}, 0);

    // CTS never ready: timeout after MAXP polls
    exp_w(3'd3, 16'h0400); exch(8'h12, 8'h00); exp_w(3'd3, 16'h0000);
    for (int i = 0; i < MAXP; i++) begin poll(8'h00); exp_w(3'd3, 16'h0000); end
    go(5'd1, 5'd2);
    wait_done("t3");
    check_eq("t3_err_timeout", err_to, 1);
    check_eq("t3_err_len", err_len, 0);
    repeat (5) tick();
    check_eq("t3_err_hold", err_to, 1);

    // Invalid length: error, done one cycle later, no bus access
    go(5'd0, 5'd0);
    check_eq("t4_done", done, 1);
    check_eq("t4_err_len", err_len, 1);
    check_eq("t4_sel", sel, 0);
    tick();
    check_eq("t4_done_pulse", done, 0);
    check_eq("t4_err_to_kept", err_to, 1);
    go(5'd2, 5'd17);
    check_eq("t4b_done", done, 1);
    check_eq("t4b_err_len", err_len, 1);
    repeat (3) tick();

    // Start and buffer writes while busy are ignored
    wr_buf(4'd0, 8'h21); wr_buf(4'd1, 8'h22);
    exp_w(3'd3, 16'h0400); exch(8'h21, 8'h00); exch(8'h22, 8'h00); exp_w(3'd3, 16'h0000);
    poll(8'hFF); exch(8'h00, 8'h5A); exp_w(3'd3, 16'h0000);
    go(5'd2, 5'd1);
    check_eq("t5_errs_cleared", {err_to, err_len}, 0);
    repeat (12) tick();
    check_eq("t5_busy_mid", busy, 1);
    clen = 5'd1; rlen = 5'd0; start = 1'b1;
    waddr = 4'd1; wdata = 8'h99; cmd_wr = 1'b1;
    tick();
    start = 1'b0; cmd_wr = 1'b0;
    wait_done("t5");
    rd_resp(4'd0, 8'h5A); rd_resp(4'd1, 8'hBB); rd_resp(4'd2, 8'hCC);

    // Reset during the second command byte
    exp_w(3'd3, 16'h0400); exch(8'h21, 8'h00); exp_w(3'd1, 16'h0022);
    go(5'd2, 5'd0);
    begin
      int n = 0;
      while (!(sel && addr == 3'd1 && swd == 16'h0022) && n < 500) begin tick(); n++; end
      check_eq("t6_second_byte", {31'h0, n < 500}, 32'h1);
    end
    reset = 1'b1;
    #1;
    check_eq("t6_rst_bus", {sel, wn, rn, addr, swd}, {3'b011, 19'h0});
    check_eq("t6_rst_status", {busy, done, err_to, err_len}, 0);
    miso_q.delete();
    check_eq("t6_exp_left", exp_q.size(), 0);
    exp_w(3'd3, 16'h0000);
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    check_eq("t6_init_acc", exp_q.size(), 0);
    check_eq("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
